// File: rtl/pipe_fifo_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_fifo_sync_if
//  Description : Valid/ready/data handshake bundle for one side of the
//                pipe_fifo_sync FIFO. The master drives valid and data, and
//                the slave drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_fifo_sync_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_fifo_sync
//  Description : Synchronous first-word-fall-through valid/ready FIFO with a
//                single-cycle flush. The head entry is presented
//                combinationally from the registered read pointer. There is
//                no bypass from in_data to out_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  pipe_fifo_sync_if.slave            in_if,
  pipe_fifo_sync_if.master           out_if,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // Handshake qualifiers. When the FIFO is full, a push is refused even if a pop happens in the same cycle.
  assign w_push = in_if.valid & ~r_full;
  assign w_pop  = out_if.ready & ~r_empty;

  assign in_if.ready  = ~r_full;
  assign out_if.valid = ~r_empty;
  assign out_if.data  = r_mem[r_rptr];

  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

  // Next occupancy. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Pointers and occupancy flags. Reset and flush both return the FIFO to the empty state.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_FULL_COUNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage write. The array is not reset. A flushed push is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !reset) begin
      r_mem[r_wptr] <= in_if.data;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full : assert property (@(posedge clk) disable iff (reset) !(w_push && r_full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset) !(w_pop && r_empty));
  a_count_max    : assert property (@(posedge clk) disable iff (reset) r_count <= C_FULL_COUNT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_fifo_sync
//  Description : Self-checking bench for pipe_fifo_sync. It checks the DUT
//                against a queue-based reference model, using directed
//                scenarios followed by a randomized soak.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_fifo_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  // Status bits, from MSB to LSB: {count[2:0], full, empty, in_ready, out_valid}
  localparam logic [6:0] ST_EMPTY = 7'b000_0110;
  localparam logic [6:0] ST_FULL  = 7'b100_1001;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int checks;
  int failures;

  // Reference model: the FIFO contents, with the head at index 0
  logic [7:0] q[$];

  pipe_fifo_sync_if #(.WIDTH(WIDTH)) in_if ();
  pipe_fifo_sync_if #(.WIDTH(WIDTH)) out_if ();

  pipe_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dut_status();
    return {count, full, empty, in_if.ready, out_if.valid};
  endfunction

  function automatic logic [6:0] exp_status();
    int n;
    n = q.size();
    return {3'(n), (n == DEPTH), (n == 0), (n != DEPTH), (n != 0)};
  endfunction

  // Apply one clock cycle of stimulus and advance the model. Outputs settle at 1 ns after the edge.
  task automatic cyc(input bit iv, input logic [7:0] d, input bit ordy, input bit fl, input bit rs);
    bit push;
    bit pop;
    in_if.valid  = iv;
    in_if.data   = d;
    out_if.ready = ordy;
    flush        = fl;
    reset        = rs;
    push = iv && (q.size() < DEPTH);
    pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    #1;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    flush        = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_status() !== ST_EMPTY) begin
      failures++;
      $display("FAIL reset_status: got %b want %b", dut_status(), ST_EMPTY);
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_status() !== exp_status()) begin
        failures++;
        $display("FAIL fill_status[%0d]: got %b want %b", i, dut_status(), exp_status());
      end
      checks++;
      if (out_if.data !== 8'h11) begin
        failures++;
        $display("FAIL fill_head[%0d]: got %h want 11", i, out_if.data);
      end
    end
    // Offer another word while full. It must be refused.
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_status() !== ST_FULL) begin
      failures++;
      $display("FAIL fill_full: got %b want %b", dut_status(), ST_FULL);
    end
    checks++;
    if (out_if.data !== 8'h11) begin
      failures++;
      $display("FAIL fill_hold: got %h want 11", out_if.data);
    end
  endtask

  task automatic test_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_if.data !== vals[i] || out_if.valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_head[%0d]: got %h/v%b want %h/v1", i, out_if.data, out_if.valid, vals[i]);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (dut_status() !== ST_EMPTY) begin
      failures++;
      $display("FAIL drain_empty: got %b want %b", dut_status(), ST_EMPTY);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    cyc(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      checks++;
      if (out_if.data !== q[0]) begin
        failures++;
        $display("FAIL simul_head[%0d]: got %h want %h", i, out_if.data, q[0]);
      end
      cyc(1'b1, d, 1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd2 || dut_status() !== exp_status()) begin
        failures++;
        $display("FAIL simul_status[%0d]: got %b want %b", i, dut_status(), exp_status());
      end
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8 && q.size() < DEPTH; i++) begin
      cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (dut_status() !== ST_FULL) begin
      failures++;
      $display("FAIL fullpop_pre: got %b want %b", dut_status(), ST_FULL);
    end
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3 || dut_status() !== exp_status()) begin
      failures++;
      $display("FAIL fullpop_count: got %b want %b", dut_status(), exp_status());
    end
    checks++;
    if (out_if.data !== q[0]) begin
      failures++;
      $display("FAIL fullpop_head: got %h want %h", out_if.data, q[0]);
    end
  endtask

  task automatic test_flush();
    cyc(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_status() !== ST_EMPTY) begin
      failures++;
      $display("FAIL flush_empty: got %b want %b", dut_status(), ST_EMPTY);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_if.data === 8'hAA || out_if.data !== q[0]) begin
        failures++;
        $display("FAIL flush_after[%0d]: got %h want %h", i, out_if.data, q[0]);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dut_status() !== ST_EMPTY) begin
      failures++;
      $display("FAIL rstmid_status: got %b want %b", dut_status(), ST_EMPTY);
    end
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_if.data !== 8'h55 || count !== 3'd1) begin
      failures++;
      $display("FAIL rstmid_head: got %h cnt %0d want 55 cnt 1", out_if.data, count);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit iv;
    bit ordy;
    bit fl;
    for (int i = 0; i < 400; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 19) == 0);
      if (q.size() > 0) begin
        checks++;
        if (out_if.data !== q[0]) begin
          failures++;
          $display("FAIL rand_head[%0d]: got %h want %h", i, out_if.data, q[0]);
        end
      end
      cyc(iv, 8'($urandom), ordy, fl, 1'b0);
      checks++;
      if (dut_status() !== exp_status()) begin
        failures++;
        $display("FAIL rand_status[%0d]: got %b want %b", i, dut_status(), exp_status());
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = 8'h00;
    out_if.ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
